// File: rtl/prefetch_unit.sv
// prefetch_unit: pipelined Avalon-MM instruction prefetcher.
// Keeps up to DEPTH reads in flight, buffers responses in an in-order FIFO and
// presents {pc, instr} pairs to decode. Redirect flushes the FIFO and discards
// every response still owed by the bus for pre-redirect reads.
module prefetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_W-1:0]   out_pc,
   output logic [DATA_W-1:0]   out_instr,
   output logic                instruction_manager_read,
   output logic [ADDR_W-1:0]   instruction_manager_address,
   output logic [DATA_W/8-1:0] instruction_manager_byteenable,
   input  logic                instruction_manager_waitrequest,
   input  logic                instruction_manager_readdatavalid,
   input  logic [DATA_W-1:0]   instruction_manager_agent_to_host
);

   localparam int STEP = DATA_W / 8;
   localparam int LSB  = $clog2(STEP);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int PW   = $clog2(DEPTH);

   localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] ALIGN_M = {ADDR_W{1'b1}} << LSB;
   localparam logic [CW:0]       DEPTH_W = (CW + 1)'(DEPTH);

   logic              read_q;
   logic [ADDR_W-1:0] address_q;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     count;
   // set while the bus still holds a command that was issued before a redirect
   logic              stale;

   logic [ADDR_W-1:0] pc_mem    [DEPTH];
   logic [DATA_W-1:0] instr_mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic              accept;
   logic              held;
   logic              drop_hit;
   logic              push;
   logic              pop;
   logic              issue;
   logic [ADDR_W-1:0] target_pc;
   logic [CW-1:0]     inflight_nx;
   logic [CW-1:0]     count_nx;
   logic [CW-1:0]     drop_nx;
   logic              stale_nx;
   logic [ADDR_W-1:0] fetch_nx;
   logic [ADDR_W-1:0] resp_nx;

   assign instruction_manager_read       = read_q;
   assign instruction_manager_address    = address_q;
   assign instruction_manager_byteenable = '1;

   assign out_valid = (count != '0);
   assign out_pc    = pc_mem[rd_ptr];
   assign out_instr = instr_mem[rd_ptr];

   // Next-state arithmetic for counters, fetch/response addresses and issue credit
   always_comb begin
      accept      = read_q && !instruction_manager_waitrequest;
      held        = read_q && instruction_manager_waitrequest;
      drop_hit    = instruction_manager_readdatavalid && (drop != '0);
      push        = instruction_manager_readdatavalid && (drop == '0) && !redirect;
      pop         = out_valid && out_ready && !redirect;
      target_pc   = redirect_pc & ALIGN_M;

      inflight_nx = inflight + CW'(accept) - CW'(instruction_manager_readdatavalid);
      count_nx    = count + CW'(push) - CW'(pop);
      drop_nx     = drop - CW'(drop_hit) + CW'(accept && stale);
      stale_nx    = stale && !accept;
      fetch_nx    = (accept && !stale) ? fetch_pc + STEP_A : fetch_pc;
      resp_nx     = push ? resp_pc + STEP_A : resp_pc;

      // everything still owed by the bus after this edge belongs to the old stream
      if (redirect) begin
         count_nx = '0;
         drop_nx  = inflight_nx;
         stale_nx = held;
         fetch_nx = target_pc;
         resp_nx  = target_pc;
      end

      // credit: reads in flight + buffered words + the new command never exceed DEPTH
      issue = !held && (({1'b0, inflight_nx} + {1'b0, count_nx}) < DEPTH_W);
   end

   // Bus command register: held under waitrequest, otherwise reloaded from credit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_q    <= 1'b0;
         address_q <= RESET_PC;
      end else if (!held) begin
         read_q <= issue;
         if (issue) begin
            address_q <= fetch_nx;
         end
      end
   end

   // Fetch/response bookkeeping and in-flight/drop/occupancy counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         count    <= '0;
         stale    <= 1'b0;
      end else begin
         fetch_pc <= fetch_nx;
         resp_pc  <= resp_nx;
         inflight <= inflight_nx;
         drop     <= drop_nx;
         count    <= count_nx;
         stale    <= stale_nx;
      end
   end

   // FIFO pointers; a redirect empties the buffer by rewinding both
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // FIFO storage; cleared on reset so out_pc/out_instr read back as zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]    <= resp_pc;
         instr_mem[wr_ptr] <= instruction_manager_agent_to_host;
      end
   end

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: randomized bench for prefetch_unit. The reference model is
// the program-order stream: after reset or a redirect to P, decode must see
// P, P+4, P+8, ... each paired with the memory word at that address.
module tb_prefetch_unit;

   localparam int          ADDR_W   = 32;
   localparam int          DATA_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        read;
   logic [31:0] address;
   logic [3:0]  byteenable;
   logic        waitrequest = 1'b0;
   logic        readdatavalid = 1'b0;
   logic [31:0] agent_to_host = '0;

   always #5 clk = ~clk;

   prefetch_unit #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk                               (clk),
      .rst                               (rst),
      .redirect                          (redirect),
      .redirect_pc                       (redirect_pc),
      .out_valid                         (out_valid),
      .out_ready                         (out_ready),
      .out_pc                            (out_pc),
      .out_instr                         (out_instr),
      .instruction_manager_read          (read),
      .instruction_manager_address       (address),
      .instruction_manager_byteenable    (byteenable),
      .instruction_manager_waitrequest   (waitrequest),
      .instruction_manager_readdatavalid (readdatavalid),
      .instruction_manager_agent_to_host (agent_to_host)
   );

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } rd_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   rd_t         rq[$];
   logic [31:0] exp_pc;
   int          cyc;
   int          wait_pct, lat_lo, lat_hi, ready_pct, redir_pm;
   logic        prev_held, prev_redir;
   logic [31:0] prev_addr;
   logic        force_redir;
   logic [31:0] force_pc;
   int          phase_accepts, phase_pops, stall;
   logic        seen_valid;
   int          first_valid_cyc, gaps;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] pick_target();
      case ($urandom_range(5, 0))
         0: return 32'h0000_0100;
         1: return 32'h0000_0040;
         2: return 32'hFFFF_FFF8;
         3: return 32'h0000_0102;
         4: return $urandom & 32'h0000_FFFC;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_mode(input int w, input int llo, input int lhi, input int rdy, input int rpm);
      wait_pct = w; lat_lo = llo; lat_hi = lhi; ready_pct = rdy; redir_pm = rpm;
      phase_accepts = 0; phase_pops = 0; stall = 0;
      seen_valid = 1'b0; first_valid_cyc = -1; gaps = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      redirect = 1'b0; out_ready = 1'b0; waitrequest = 1'b0; readdatavalid = 1'b0;
      rq.delete();
      exp_pc = RESET_PC;
      prev_held = 1'b0; prev_redir = 1'b0; force_redir = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_read", {31'd0, read}, 32'd0);
      check_eq("rst_address", address, RESET_PC);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_pc", out_pc, 32'd0);
      check_eq("rst_out_instr", out_instr, 32'd0);
      check_eq("byteenable", {28'd0, byteenable}, 32'hF);
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic run_cycles(input int n);
      rd_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         if (prev_redir) check_eq("valid_after_redirect", {31'd0, out_valid}, 32'd0);
         if (prev_held) begin
            check_eq("hold_read", {31'd0, read}, 32'd1);
            check_eq("hold_address", address, prev_addr);
         end
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (seen_valid && !out_valid) gaps++;
         if (out_valid) seen_valid = 1'b1;

         waitrequest = ($urandom_range(99, 0) < wait_pct);
         out_ready   = ($urandom_range(99, 0) < ready_pct);
         if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
         end else begin
            redirect = ($urandom_range(999, 0) < redir_pm);
            if (redirect) redirect_pc = pick_target();
         end
         readdatavalid = 1'b0;
         agent_to_host = $urandom;
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            readdatavalid = 1'b1;
            agent_to_host = mem_word(rq[0].addr);
            void'(rq.pop_front());
         end

         if (out_valid && out_ready && !redirect) begin
            check_eq("out_pc", out_pc, exp_pc);
            check_eq("out_instr", out_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            phase_pops++;
            stall = 0;
         end else begin
            stall++;
         end
         if (read && !waitrequest) begin
            e.addr = address;
            e.due  = cyc + $urandom_range(lat_hi, lat_lo);
            rq.push_back(e);
            phase_accepts++;
            check_eq("inflight_bound", {31'd0, rq.size() <= DEPTH}, 32'd1);
         end
         if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;

         prev_redir = redirect;
         prev_held  = read && waitrequest;
         prev_addr  = address;
         if (ready_pct > 0 && stall > 400) begin
            check_eq("progress_stall", stall, 0);
            stall = 0;
         end
      end
   endtask

   task automatic forced_redirect(input logic [31:0] pc);
      force_redir = 1'b1;
      force_pc    = pc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      set_mode(0, 1, 1, 100, 0);
      do_reset();

      // zero-wait, 1-cycle memory, consumer always ready
      set_mode(0, 1, 1, 100, 0);
      run_cycles(40);
      check_eq("startup_cycle", first_valid_cyc, 3);
      check_eq("stream_gaps", gaps, 0);
      check_eq("stream_pops", phase_pops, 38);

      // consumer stalled: exactly DEPTH reads, then bus goes idle with a full FIFO
      do_reset();
      set_mode(0, 1, 3, 0, 0);
      run_cycles(30);
      check_eq("stalled_accepts", phase_accepts, DEPTH);
      check_eq("stalled_read", {31'd0, read}, 32'd0);
      check_eq("stalled_valid", {31'd0, out_valid}, 32'd1);
      set_mode(0, 1, 1, 100, 0);
      run_cycles(20);
      check_eq("resume_pops", {31'd0, phase_pops > 10}, 32'd1);

      // long latency with redirects landing on in-flight reads
      set_mode(0, 5, 5, 70, 40);
      run_cycles(600);
      check_eq("latency_progress", {31'd0, phase_pops > 50}, 32'd1);

      // waitrequest held across a redirect
      set_mode(100, 1, 2, 100, 0);
      run_cycles(2);
      forced_redirect(32'h0000_0040);
      run_cycles(4);
      set_mode(0, 1, 2, 100, 0);
      run_cycles(20);
      check_eq("held_redirect_pops", {31'd0, phase_pops > 5}, 32'd1);

      // address wrap and unaligned redirect target
      set_mode(0, 1, 1, 100, 0);
      forced_redirect(32'hFFFF_FFF8);
      run_cycles(20);
      check_eq("wrap_pops", {31'd0, phase_pops >= 3}, 32'd1);
      set_mode(0, 1, 1, 100, 0);
      forced_redirect(32'h0000_0102);
      run_cycles(20);
      check_eq("unaligned_pops", {31'd0, phase_pops >= 3}, 32'd1);

      // fully random traffic
      set_mode(40, 1, 6, 60, 30);
      run_cycles(2500);
      check_eq("random_progress", {31'd0, phase_pops > 200}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
